// File: rtl/node_phase_scheduler.sv
// Step scheduler for the node array: one-hot verlet pulses across all nodes, then
// CONSTRAINT_ITERS constraint passes, waiting on each node's finish with a timeout.
module node_phase_scheduler #(
  parameter int NODE_COUNT       = 5,
  parameter int CONSTRAINT_ITERS = 4,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int IDX_W            = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  free_run,
  input  logic [NODE_COUNT-1:0] finish,
  output logic [NODE_COUNT-1:0] verlet_en,
  output logic [NODE_COUNT-1:0] constraint_en,
  output logic [IDX_W-1:0]      node_idx,
  output logic [7:0]            iter_idx,
  output logic                  busy,
  output logic                  step_done,
  output logic [31:0]           step_count,
  output logic                  timeout_err
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]      NODE_LAST = IDX_W'(NODE_COUNT - 1);
  localparam logic [7:0]            ITER_LAST = 8'(CONSTRAINT_ITERS - 1);
  localparam logic [NODE_COUNT-1:0] NODE_ONE  = NODE_COUNT'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_V_ISSUE, S_V_WAIT, S_C_ISSUE, S_C_WAIT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  node_q, node_d;
  logic [7:0]        iter_q, iter_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       count_q, count_d;
  logic              err_q, err_d;
  logic              node_fin;
  logic              wait_end;

  assign node_fin = finish[node_q];
  // The last permitted wait cycle still honours finish before it counts as a timeout.
  assign wait_end = node_fin || (wait_q == WAIT_LAST);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no latch is
    // inferred; blocking assignments are correct in combinational logic.
    state_d = state_q;
    node_d  = node_q;
    iter_d  = iter_q;
    wait_d  = wait_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_V_ISSUE;
          node_d  = '0;
          iter_d  = '0;
        end
      end
      S_V_ISSUE: begin
        state_d = S_V_WAIT;
        wait_d  = '0;
      end
      S_V_WAIT: begin
        if (wait_end) begin
          if (!node_fin) err_d = 1'b1;
          if (node_q != NODE_LAST) begin
            node_d  = node_q + IDX_W'(1);
            state_d = S_V_ISSUE;
          end else begin
            node_d  = '0;
            iter_d  = '0;
            state_d = S_C_ISSUE;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_C_ISSUE: begin
        state_d = S_C_WAIT;
        wait_d  = '0;
      end
      S_C_WAIT: begin
        if (wait_end) begin
          if (!node_fin) err_d = 1'b1;
          if (node_q != NODE_LAST) begin
            node_d  = node_q + IDX_W'(1);
            state_d = S_C_ISSUE;
          end else if (iter_q != ITER_LAST) begin
            node_d  = '0;
            iter_d  = iter_q + 8'd1;
            state_d = S_C_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DONE: begin
        count_d = count_q + 32'd1;
        node_d  = '0;
        iter_d  = '0;
        state_d = free_run ? S_V_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      node_q  <= '0;
      iter_q  <= '0;
      wait_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state_q <= state_d;
      node_q  <= node_d;
      iter_q  <= iter_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registers, so an asserted reset clears them at once.
  assign verlet_en     = (state_q == S_V_ISSUE) ? (NODE_ONE << node_q) : '0;
  assign constraint_en = (state_q == S_C_ISSUE) ? (NODE_ONE << node_q) : '0;
  assign node_idx      = node_q;
  assign iter_idx      = iter_q;
  assign busy          = (state_q != S_IDLE);
  assign step_done     = (state_q == S_DONE);
  assign step_count    = count_q;
  assign timeout_err   = err_q;

endmodule

// File: doc/node_phase_scheduler.md
Name: node_phase_scheduler

Overview:
- Parametrised successor to the fixed five-node verlet sequencer.
- Drives one-hot per-node enables for a verlet-integration phase, then CONSTRAINT_ITERS passes of a constraint-enforcement phase.
- Waits on each node's finish signal, with a per-node timeout, before moving to the next node.
- Sits between the simulation core's node array and the top-level step control; one simulation step per start or free-run cycle.

Parameters:
- NODE_COUNT, 5, number of nodes scheduled (>=1).
- CONSTRAINT_ITERS, 4, constraint passes per step (>=1).
- TIMEOUT_CYCLES, 255, maximum WAIT cycles per node before skipping (>=1).
- IDX_W, $clog2(NODE_COUNT) min 1, width of node index.

Ports:
- clk  in  1  system clock; rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one step; sampled in IDLE only.
- free_run  in  1  when high at DONE, next step starts without start.
- finish  in  NODE_COUNT  per-node completion; bit i meaningful only while node i is being waited on.
- verlet_en  out  NODE_COUNT  one-hot verlet-phase enable.
- constraint_en  out  NODE_COUNT  one-hot constraint-phase enable.
- node_idx  out  IDX_W  node currently scheduled.
- iter_idx  out  8  current constraint pass (0-based); 0 during verlet phase.
- busy  out  1  high in any state except IDLE.
- step_done  out  1  one-cycle pulse at step completion.
- step_count  out  32  completed steps; wraps 2^32-1 -> 0.
- timeout_err  out  1  sticky; set on any node timeout; cleared only by reset.

Behaviour:
- Reset (async, reset=0): state IDLE, all outputs 0, internal counters 0. Applies mid-operation; enables drop immediately, not at the next edge.
- FSM states: IDLE, V_ISSUE, V_WAIT, C_ISSUE, C_WAIT, DONE.
- IDLE: when start=1, go to V_ISSUE with node_idx=0.
- V_ISSUE (1 cycle): verlet_en = 1<<node_idx; then V_WAIT. Enables are single-cycle pulses; both enable vectors are 0 in every other state.
- V_WAIT: finish[node_idx] sampled each cycle, starting the cycle after ISSUE. Other finish bits, and finish during ISSUE, are ignored.
  - On finish: if node_idx<NODE_COUNT-1, increment node_idx and go to V_ISSUE.
  - Otherwise go to C_ISSUE with node_idx=0 and iter_idx=0.
- Timeout: a wait counter resets on entry to each WAIT state.
  - If TIMEOUT_CYCLES WAIT cycles pass without finish, set timeout_err and advance exactly as if finish arrived.
  - finish in the final permitted cycle counts as finish, not timeout.
- C_ISSUE / C_WAIT: identical rules using constraint_en.
  - After the last node: if iter_idx<CONSTRAINT_ITERS-1, increment iter_idx, set node_idx=0, go to C_ISSUE.
  - Otherwise go to DONE.
- DONE (1 cycle): step_done=1, step_count increments. Then:
  - free_run=1: go to V_ISSUE with node_idx=0, iter_idx=0.
  - free_run=0: go to IDLE; node_idx and iter_idx return to 0.
- start while busy is ignored; it is not queued.
- Latency: start sampled at edge 0 gives V_ISSUE(node0) in cycle 1. With finish returned in the first WAIT cycle, each node takes 2 cycles. Step length is 2*NODE_COUNT*(1+CONSTRAINT_ITERS) cycles followed by one DONE cycle; defaults give 50+1.
- busy=0 only in IDLE; step_done and busy are both high in DONE.

Test Plan:
- Reset then start=1 for one cycle, finish echoed one cycle after each enable. Required:
  - verlet_en pulses 00001,00010,00100,01000,10000 on cycles 1,3,5,7,9.
  - constraint_en repeats the pattern 4 times.
  - step_done at cycle 51, step_count=1, timeout_err=0.
- Node 2 holds finish low, TIMEOUT_CYCLES=255. Required: V_WAIT lasts 255 cycles, then verlet_en=01000. timeout_err=1 and stays 1 through the next step.
- During V_WAIT on node 1, assert finish=11101 (bit 1 low). Required: no advance. Then finish=00010 gives verlet_en=00100 two cycles later.
- free_run=1 for 3 steps. Required: V_ISSUE node0 on the cycle after each DONE, step_count=3, busy stays high. start pulses mid-step have no effect.
- Assert reset=0 asynchronously mid-C_WAIT (iter 2, node 3). Required: enables, busy, step_count and node_idx go to 0 before the next clk edge. After release, the FSM is in IDLE.
- NODE_COUNT=1, CONSTRAINT_ITERS=1. Required: verlet_en=1 at cycle 1, constraint_en=1 at cycle 3, step_done at cycle 5. Preload step_count=32'hFFFFFFFF and check it wraps to 0.
